frame_wr_ctrl: RTL

FRAME_WR_CTRL -- requirements
Module: frame_wr_ctrl

---
 rtl/frame_buf_pkg.sv | 24 ++
 rtl/burst_addr_cnt.sv | 44 ++++
 rtl/frame_wr_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_buf_pkg.sv
// Shared frame-buffer definitions for the DDR write- and read-side controllers.
package frame_buf_pkg;

    localparam int FB_H_DISP      = 640;
    localparam int FB_V_DISP      = 480;
    localparam int FB_BURST_LEN   = 64;
    localparam int FB_ADDR_W      = 24;
    localparam int FB_FRAME_WORDS = FB_H_DISP * FB_V_DISP;

    // Burst sequencing states shared by both controllers
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_REQ       = 3'd2,
        S_BURST     = 3'd3,
        S_NEXT      = 3'd4
    } fb_state_e;

    // Words in one frame for a given raster size
    function automatic int frame_words(input int h_disp, input int v_disp);
        return h_disp * v_disp;
    endfunction

endpackage

// File: rtl/burst_addr_cnt.sv
// Burst offset counter with terminal-count detect; one count step is one burst.
module burst_addr_cnt
    import frame_buf_pkg::*;
#(
    parameter int CNT_W = FB_ADDR_W - 2,
    parameter int STEP  = FB_BURST_LEN,
    parameter int TERM  = FB_FRAME_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_offset,
    output logic             o_last
);

    localparam logic [CNT_W:0] C_STEP = (CNT_W + 1)'(STEP);
    localparam logic [CNT_W:0] C_TERM = (CNT_W + 1)'(TERM);

    logic [CNT_W-1:0] r_offset;
    logic [CNT_W:0]   w_sum;

    // Offset after the current burst, one bit wider so a frame filling the whole bank still matches
    always_comb begin
        w_sum = {1'b0, r_offset} + C_STEP;
    end

    assign o_last   = (w_sum == C_TERM);
    assign o_offset = r_offset;

    // Offset register: a clear (new frame) wins over an increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_offset <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_offset <= {CNT_W{1'b0}};
        end else if (i_inc) begin
            r_offset <= w_sum[CNT_W-1:0];
        end else begin
            r_offset <= r_offset;
        end
    end

endmodule

// File: rtl/frame_wr_ctrl.sv
// Write-side frame buffer controller: moves one camera frame into a DDR bank
// as a sequence of fixed-length bursts, one burst outstanding at a time.
module frame_wr_ctrl
    import frame_buf_pkg::*;
#(
    parameter int H_DISP    = FB_H_DISP,
    parameter int V_DISP    = FB_V_DISP,
    parameter int BURST_LEN = FB_BURST_LEN,
    parameter int ADDR_W    = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_load,
    input  logic [1:0]        wr_bank,
    input  logic [9:0]        fifo_rdusedw,
    output logic              ddr_wr_req,
    output logic [ADDR_W-1:0] ddr_wr_addr,
    output logic [7:0]        ddr_wr_len,
    input  logic              ddr_wr_ack,
    input  logic              ddr_wr_done,
    output logic              frame_write_done
);

    localparam int          FRAME_WORDS = frame_words(H_DISP, V_DISP);
    localparam int          OFF_W       = ADDR_W - 2;
    localparam logic [10:0] C_FIFO_THR  = 11'(BURST_LEN);
    localparam logic [7:0]  C_LEN       = 8'(BURST_LEN);

    fb_state_e         r_state;
    fb_state_e         w_state_nxt;
    logic [1:0]        r_bank;
    logic              r_pend;
    logic [1:0]        r_pend_bank;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;
    logic [7:0]        r_len;

    logic [OFF_W-1:0]  w_offset;
    logic              w_last;
    logic              w_fifo_ok;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_bank_ld_in;
    logic              w_bank_ld_pend;
    logic              w_pend_set;
    logic              w_pend_clr;
    logic              w_done_set;
    logic              w_done_clr;

    assign w_fifo_ok = ({1'b0, fifo_rdusedw} >= C_FIFO_THR);

    burst_addr_cnt #(
        .CNT_W (OFF_W),
        .STEP  (BURST_LEN),
        .TERM  (FRAME_WORDS)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_cnt_clr),
        .i_inc    (w_cnt_inc),
        .o_offset (w_offset),
        .o_last   (w_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control; a load seen mid-transaction is deferred to NEXT
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_clr      = 1'b0;
        w_cnt_inc      = 1'b0;
        w_bank_ld_in   = 1'b0;
        w_bank_ld_pend = 1'b0;
        w_pend_set     = 1'b0;
        w_pend_clr     = 1'b0;
        w_done_set     = 1'b0;
        w_done_clr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr_load) begin
                    w_cnt_clr    = 1'b1;
                    w_bank_ld_in = 1'b1;
                    w_done_clr   = 1'b1;
                    w_state_nxt  = S_WAIT_DATA;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                if (wr_load) begin
                    w_cnt_clr    = 1'b1;
                    w_bank_ld_in = 1'b1;
                    w_state_nxt  = S_WAIT_DATA;
                end else if (w_fifo_ok) begin
                    w_state_nxt  = S_REQ;
                end else begin
                    w_state_nxt  = S_WAIT_DATA;
                end
            end
            S_REQ: begin
                w_pend_set = wr_load;
                if (ddr_wr_ack) begin
                    w_state_nxt = S_BURST;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_BURST: begin
                w_pend_set = wr_load;
                if (ddr_wr_done) begin
                    w_state_nxt = S_NEXT;
                end else begin
                    w_state_nxt = S_BURST;
                end
            end
            S_NEXT: begin
                w_pend_clr = 1'b1;
                if (wr_load) begin
                    w_cnt_clr      = 1'b1;
                    w_bank_ld_in   = 1'b1;
                    w_state_nxt    = S_WAIT_DATA;
                end else if (r_pend) begin
                    w_cnt_clr      = 1'b1;
                    w_bank_ld_pend = 1'b1;
                    w_state_nxt    = S_WAIT_DATA;
                end else if (w_last) begin
                    w_cnt_inc      = 1'b1;
                    w_done_set     = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_cnt_inc      = 1'b1;
                    w_state_nxt    = S_WAIT_DATA;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bank latch and deferred-load bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank      <= 2'b00;
            r_pend      <= 1'b0;
            r_pend_bank <= 2'b00;
        end else begin
            if (w_bank_ld_in) begin
                r_bank <= wr_bank;
            end else if (w_bank_ld_pend) begin
                r_bank <= r_pend_bank;
            end else begin
                r_bank <= r_bank;
            end
            if (w_pend_set) begin
                r_pend      <= 1'b1;
                r_pend_bank <= wr_bank;
            end else if (w_pend_clr) begin
                r_pend      <= 1'b0;
                r_pend_bank <= r_pend_bank;
            end else begin
                r_pend      <= r_pend;
                r_pend_bank <= r_pend_bank;
            end
        end
    end

    // Registered outputs; the address is captured on entry to REQ so it is stable while requesting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req  <= 1'b0;
            r_addr <= {ADDR_W{1'b0}};
            r_done <= 1'b0;
            r_len  <= C_LEN;
        end else begin
            r_req <= (w_state_nxt == S_REQ);
            r_len <= C_LEN;
            if ((r_state != S_REQ) && (w_state_nxt == S_REQ)) begin
                r_addr <= {r_bank, w_offset};
            end else begin
                r_addr <= r_addr;
            end
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end else begin
                r_done <= r_done;
            end
        end
    end

    assign ddr_wr_req       = r_req;
    assign ddr_wr_addr      = r_addr;
    assign ddr_wr_len       = r_len;
    assign frame_write_done = r_done;

endmodule
